// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and special divide results.
package rv32m_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DIV0_QUO     = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUO      = 32'h8000_0000;
    localparam logic [31:0] OVF_REM      = 32'h0000_0000;

    function automatic logic op_is_mul(input logic [2:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_signed_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_wants_quo(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_mul_div_unit_div_step.sv
// One restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor and keep the difference if non-negative.
module div_restoring_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic [31:0] next_quo
);

    logic [32:0] shifted;
    logic [32:0] trial;

    assign shifted = {rem, quo[31]};
    assign trial   = shifted - {1'b0, divisor};

    // rem < divisor keeps the shifted value below 2*divisor,
    // so bit 32 of the trial is a clean borrow flag.
    always_comb begin
        if (!trial[32]) begin
            next_rem = trial[31:0];
            next_quo = {quo[30:0], 1'b1};
        end else begin
            next_rem = shifted[31:0];
            next_quo = {quo[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_mul_div_unit.sv
// Iterative RV32M multiply/divide unit in EX: one-cycle multiply,
// 32-cycle restoring divide, stalls the pipeline through BUSY.
module ex_mul_div_unit
    import rv32m_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [31:0] OPERAND_A,
    input  logic [31:0] OPERAND_B,
    input  logic        HOLD,
    input  logic        KILL,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [5:0]  cnt;

    logic        start_mul;
    logic        start_div;
    logic        start_special;
    logic [31:0] a_start_mag;

    assign start_mul     = op_is_mul(OP);
    assign start_div     = op_is_div(OP);
    assign start_special = (OPERAND_B == 32'd0)
                         || (op_signed_div(OP)
                             && OPERAND_A == OVF_DIVIDEND
                             && OPERAND_B == OVF_DIVISOR);
    assign a_start_mag   = (op_signed_div(OP) && OPERAND_A[31])
                         ? -OPERAND_A : OPERAND_A;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] divisor;
    logic [31:0] next_rem;
    logic [31:0] next_quo;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign a_neg   = op_signed_div(op_q) && a_q[31];
    assign b_neg   = op_signed_div(op_q) && b_q[31];
    assign divisor = b_neg ? -b_q : b_q;
    assign quo_fix = (a_neg ^ b_neg) ? -next_quo : next_quo;
    assign rem_fix = a_neg ? -next_rem : next_rem;

    div_restoring_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    // The low 64 bits of the 33x33 product are all RV32M ever reads.
    logic        a_sx;
    logic        b_sx;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] mul_res;

    assign a_sx    = a_q[31] && (op_q == OP_MULH || op_q == OP_MULHSU);
    assign b_sx    = b_q[31] && (op_q == OP_MULH);
    assign a_ext   = {{32{a_sx}}, a_q};
    assign b_ext   = {{32{b_sx}}, b_q};
    assign prod    = a_ext * b_ext;
    assign mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    unique case (1'b1)
                        start_mul:
                            state_next = ST_MUL;
                        start_div && start_special:
                            state_next = ST_DONE;
                        start_div && !start_special:
                            state_next = ST_DIV;
                        default:
                            state_next = ST_IDLE;
                    endcase
                end
            end
            ST_MUL:  state_next = ST_DONE;
            ST_DIV:  if (cnt == 6'd31) state_next = ST_DONE;
            ST_DONE: if (!HOLD) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (KILL) state_next = ST_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            cnt    <= 6'd0;
            RESULT <= 32'd0;
        end else if (!KILL) begin
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        op_q  <= OP;
                        a_q   <= OPERAND_A;
                        b_q   <= OPERAND_B;
                        cnt   <= 6'd0;
                        rem_q <= 32'd0;
                        quo_q <= a_start_mag;
                        if (start_div && OPERAND_B == 32'd0)
                            RESULT <= op_wants_quo(OP) ? DIV0_QUO : OPERAND_A;
                        else if (start_div && start_special)
                            RESULT <= op_wants_quo(OP) ? OVF_QUO : OVF_REM;
                    end
                end
                ST_MUL: RESULT <= mul_res;
                ST_DIV: begin
                    cnt   <= cnt + 6'd1;
                    rem_q <= next_rem;
                    quo_q <= next_quo;
                    if (cnt == 6'd31)
                        RESULT <= op_wants_quo(op_q) ? quo_fix : rem_fix;
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY = !RESET && !KILL
               && ((state == ST_IDLE && START)
                   || state == ST_MUL
                   || state == ST_DIV);
    assign DONE = !RESET && (state == ST_DONE);

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Scoreboard bench for ex_mul_div_unit: arithmetic reference model,
// queued expectations popped by a monitor on each result hand-off.
module tb_ex_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  OP;
    logic [31:0] OPERAND_A;
    logic [31:0] OPERAND_B;
    logic        HOLD;
    logic        KILL;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    ex_mul_div_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .OP        (OP),
        .OPERAND_A (OPERAND_A),
        .OPERAND_B (OPERAND_B),
        .HOLD      (HOLD),
        .KILL      (KILL),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        longint             p;
        longint unsigned    up;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return a * b;
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                return p[63:32];
            end
            3'd2: begin
                p = longint'(sa) * longint'({32'd0, b});
                return p[63:32];
            end
            3'd3: begin
                up = {32'd0, a} * {32'd0, b};
                return up[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op < 3'd4) return 2;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6)
            && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    always @(negedge CLK) begin
        if (!RESET && DONE && !HOLD && !KILL) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result actual=%h expected=none", RESULT);
            end else begin
                chk("result", RESULT, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold_n);
        int          lat;
        int          cyc;
        logic [31:0] r;
        @(posedge CLK) #1;
        OP        = op;
        OPERAND_A = a;
        OPERAND_B = b;
        START     = 1'b1;
        HOLD      = (hold_n > 0);
        lat       = ref_lat(op, a, b);
        r         = ref_res(op, a, b);
        exp_q.push_back(r);
        last_res  = r;
        cyc       = 0;
        forever begin
            @(negedge CLK);
            if (DONE) break;
            chk("busy", {31'd0, BUSY}, 32'd1);
            if (cyc > 40) begin
                checks++;
                failures++;
                $display("FAIL timeout actual=%0d expected=%0d", cyc, lat);
                break;
            end
            @(posedge CLK) #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("busy_in_done", {31'd0, BUSY}, 32'd0);
        for (int i = 0; i < hold_n; i++) begin
            @(posedge CLK) #1;
            if (i == hold_n - 1) HOLD = 1'b0;
            @(negedge CLK);
            chk("hold_done", {31'd0, DONE}, 32'd1);
            chk("hold_result", RESULT, r);
        end
        @(posedge CLK) #1;
        START = 1'b0;
        HOLD  = 1'b0;
        @(negedge CLK);
        chk("exit_busy", {31'd0, BUSY}, 32'd0);
        chk("exit_done", {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        RESET     = 1'b1;
        START     = 1'b1;
        OP        = 3'd4;
        OPERAND_A = 32'd9;
        OPERAND_B = 32'd3;
        HOLD      = 1'b0;
        KILL      = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_done", {31'd0, DONE}, 32'd0);
        @(posedge CLK) #1;
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("reset_result", RESULT, 32'd0);
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 1);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd4, 32'hFFFF_FFEC, 32'd6, 3);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd6, 0);
        run_op(3'd5, 32'd100, 32'd0, 0);
        run_op(3'd7, 32'd100, 32'd0, 2);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'd0, 0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0);

        @(posedge CLK) #1;
        OP        = 3'd4;
        OPERAND_A = 32'd1000;
        OPERAND_B = 32'd7;
        START     = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        KILL  = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        chk("kill_busy", {31'd0, BUSY}, 32'd0);
        @(posedge CLK) #1;
        KILL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("kill_done", {31'd0, DONE}, 32'd0);
            chk("kill_idle", {31'd0, BUSY}, 32'd0);
            chk("kill_result", RESULT, last_res);
            @(posedge CLK) #1;
        end

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 15);
                default: ;
            endcase
            run_op(rop, ra, rb, $urandom_range(0, 2));
        end

        run_op(3'd0, 32'd7, 32'd3, 0);
        @(posedge CLK) #1;
        OP        = 3'd0;
        OPERAND_A = 32'd5;
        OPERAND_B = 32'd6;
        START     = 1'b1;
        @(posedge CLK) #1;
        RESET = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        @(posedge CLK) #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mid_result", RESULT, 32'd0);
        chk("rst_mid_done", {31'd0, DONE}, 32'd0);
        chk("rst_mid_idle", {31'd0, BUSY}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_no_done", {31'd0, DONE}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
